multi_team_scorer: RTL and testbench
====================================

# multi_team_scorer

Parametrised scoreboard core for the sports-scorer design. It debounces four push keys and keeps saturating two-digit BCD scores for up to four teams. Add/subtract mode, team selection and clear are key-driven. The block drives a time-multiplexed common seven-segment display with leading-zero blanking. It replaces the fixed two-digit scorer in the top level.

## Interface
- TEAMS, 2: number of team scores, 1..4; display has 2*TEAMS digits.
- MAX_SCORE, 99: saturation limit, 1..99.
- DEB_CYCLES, 4: consecutive stable cycles before a key level is accepted, >=1.
- SCAN_CYCLES, 4: clock cycles each digit is shown, >=1.

- I_clk  in  1  single clock, rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_key_A  in  1  mode toggle key: add/subtract, active-high, asynchronous.
- I_key_B  in  1  score key: apply ±1 to the selected team.
- I_key_C  in  1  team-select key: advance the selection.
- I_key_D  in  1  clear key: zero all scores.
- o_led  out  7  segments {g,f,e,d,c,b,a}, active-high.
- o_dx  out  2*TEAMS  one-hot digit enable, active-high.
- o_mode  out  1  0 = add, 1 = subtract.
- o_sel  out  2  selected team index.

## Operation
- **Key front end** (per key):
  - Raw input passes a 2-flop synchroniser.
  - A counter counts cycles where the synchronised level differs from the debounced level. It clears whenever they match.
  - When the counter reaches DEB_CYCLES, the debounced level flips.
  - A registered one-cycle press pulse fires on each debounced rising edge. Release edges generate nothing.
- **Same-cycle press pulses**:
  - D clears every score to 00 and suppresses B that cycle.
  - A toggles o_mode.
  - C advances o_sel; it wraps TEAMS-1 -> 0. With TEAMS=1, o_sel stays 0.
  - B updates team o_sel using the pre-update o_mode and o_sel values.
  - A, C and B/D all take effect in the same cycle.
- **Scores**: two BCD digits per team.
  - Add at MAX_SCORE: holds (saturates).
  - Add otherwise: +1, with ones digit 9 -> 0 carrying into tens.
  - Subtract at 00: holds.
  - Subtract otherwise: -1, with ones digit 0 -> 9 borrowing from tens.
- **Display scan**:
  - Digit index k runs 0..2*TEAMS-1 and wraps.
  - k advances every SCAN_CYCLES cycles.
  - Digit 2t is team t ones; digit 2t+1 is team t tens.
  - A tens digit of 0 is blanked (o_led = 7'h00).
- **Segment decode** for digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- **Output coherence**: o_led and o_dx are registered and change in the same cycle, so they never mismatch.

## Timing
- **Reset** (asynchronous; immediate, no clock needed):
  - All scores 00, o_mode=0, o_sel=0.
  - Debounced levels 0, counters 0, k=0.
  - o_dx = one-hot bit 0, o_led = 7'h3F.
- **Press latency**: let edge 0 be the first rising edge sampling the raw key high, with the key held high.
  - Debounced level rises at edge DEB_CYCLES+2.
  - Press pulse is high after edge DEB_CYCLES+3.
  - Score, o_mode and o_sel update at edge DEB_CYCLES+4.
- **Glitch rejection**: a raw pulse or bounce shorter than DEB_CYCLES cycles produces no press.
- **Held keys**:
  - A key held continuously gives exactly one press.
  - A new press requires a debounced release, i.e. DEB_CYCLES stable-low cycles.
  - A key held through reset release yields one press at DEB_CYCLES+4 edges after the first edge following deassertion.
- **Display latency**: a score change reaches o_led no later than the next time its digit is scanned, plus 1 cycle.
- **Scan timing**:
  - Each o_dx bit is high for exactly SCAN_CYCLES consecutive cycles.
  - The full frame is 2*TEAMS*SCAN_CYCLES cycles.
- **Reset mid-operation**: abandons any in-progress debounce count and scan position; the first frame after reset starts at digit 0.

## Test plan
Defaults apply unless noted: 10 ns clock. Keys are held 20 cycles high, then 20 cycles low.

- Reset, then 3 B presses -> team0 = 03. When o_dx=4'b0001, o_led = 7'h4F; when o_dx=4'b0010, o_led = 7'h00 (blanked). o_mode=0.
- Continuing, A press then 4 B presses -> o_mode=1; team0 steps 02, 01, 00, 00 (holds at zero).
- C press then 2 B presses in add mode -> o_sel=1, team1 = 02, team0 unchanged. C pressed at TEAMS=2 with o_sel=1 -> o_sel wraps to 0.
- Carry and saturation, MAX_SCORE=12: 10 B presses -> team0 = 10, giving tens digit o_led = 7'h06 and ones digit 7'h3F. 5 further presses -> team0 = 12, held.
- B high for 3 cycles only -> no score change. Then D and B pressed on the same edge -> all scores 00; o_mode and o_sel unchanged.
- I_rst_n pulled low asynchronously between clock edges mid-frame -> o_dx = 4'b0001, o_led = 7'h3F, o_mode=0, o_sel=0, all before the next clock edge.

Source files
------------

// File: rtl/multi_team_scorer.sv
// Multi-team scoreboard core: debounced keys, saturating two-digit BCD scores
// per team, and a registered time-multiplexed seven-segment scan with tens blanking.
module multi_team_scorer #(
    parameter int TEAMS       = 2,
    parameter int MAX_SCORE   = 99,
    parameter int DEB_CYCLES  = 4,
    parameter int SCAN_CYCLES = 4
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_key_A,
    input  logic               I_key_B,
    input  logic               I_key_C,
    input  logic               I_key_D,
    output logic [6:0]         o_led,
    output logic [2*TEAMS-1:0] o_dx,
    output logic               o_mode,
    output logic [1:0]         o_sel
);

    localparam int ND = 2 * TEAMS;
    localparam int KW = $clog2(ND);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [7:0] MAX_BCD = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == MAX_BCD) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) return v;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Key bit order throughout: [0]=A mode, [1]=B score, [2]=C select, [3]=D clear
    logic [3:0]    key_raw;
    logic [3:0]    sync1_q, sync2_q, deb_q, deb_dly_q, press_q;
    logic [DW-1:0] cnt_q [4];

    assign key_raw = {I_key_D, I_key_C, I_key_B, I_key_A};

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DW'(DEB_CYCLES)) begin
                    cnt_q[i] <= '0;
                    deb_q[i] <= ~deb_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic       mode_q, mode_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] score_q [TEAMS];
    logic [7:0] score_d [TEAMS];

    // B acts on the pre-update mode/select; D wins over B
    always_comb begin
        mode_d = mode_q ^ press_q[0];
        sel_d  = sel_q;
        if (press_q[2]) sel_d = (sel_q == 2'(TEAMS - 1)) ? 2'd0 : sel_q + 2'd1;
        for (int t = 0; t < TEAMS; t++) begin
            score_d[t] = score_q[t];
            if (press_q[3])
                score_d[t] = 8'h00;
            else if (press_q[1] && sel_q == 2'(t))
                score_d[t] = mode_q ? bcd_dec(score_q[t]) : bcd_inc(score_q[t]);
        end
    end

    logic [SW-1:0] cyc_q, cyc_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    shown;
    logic [3:0]    nib;
    logic [6:0]    led_q, led_d;
    logic [ND-1:0] dx_q, dx_d;

    // Segments and digit enable are both derived from the next digit index
    always_comb begin
        cyc_d = cyc_q + 1'b1;
        k_d   = k_q;
        if (cyc_q == SW'(SCAN_CYCLES - 1)) begin
            cyc_d = '0;
            k_d   = (k_q == KW'(ND - 1)) ? '0 : k_q + 1'b1;
        end
        shown = 8'h00;
        for (int t = 0; t < TEAMS; t++) begin
            if ((k_d >> 1) == KW'(t)) shown = score_q[t];
        end
        nib   = k_d[0] ? shown[7:4] : shown[3:0];
        led_d = (k_d[0] && nib == 4'd0) ? 7'h00 : seg7(nib);
        dx_d  = ND'(1) << k_d;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mode_q <= 1'b0;
            sel_q  <= 2'd0;
            for (int t = 0; t < TEAMS; t++) score_q[t] <= 8'h00;
            cyc_q  <= '0;
            k_q    <= '0;
            led_q  <= 7'h3F;
            dx_q   <= ND'(1);
        end else begin
            mode_q <= mode_d;
            sel_q  <= sel_d;
            for (int t = 0; t < TEAMS; t++) score_q[t] <= score_d[t];
            cyc_q  <= cyc_d;
            k_q    <= k_d;
            led_q  <= led_d;
            dx_q   <= dx_d;
        end
    end

    assign o_led  = led_q;
    assign o_dx   = dx_q;
    assign o_mode = mode_q;
    assign o_sel  = sel_q;

endmodule

// File: tb/tb_multi_team_scorer.sv
// Directed bench for multi_team_scorer: default instance plus a MAX_SCORE=12 instance.
module tb_multi_team_scorer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] k0 = 4'b0;
    logic [3:0] k12 = 4'b0;
    logic [6:0] led0, led12;
    logic [3:0] dx0, dx12;
    logic       mode0, mode12;
    logic [1:0] sel0, sel12;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_team_scorer #(.TEAMS(2), .MAX_SCORE(99), .DEB_CYCLES(4), .SCAN_CYCLES(4)) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_key_A(k0[0]), .I_key_B(k0[1]), .I_key_C(k0[2]), .I_key_D(k0[3]),
        .o_led(led0), .o_dx(dx0), .o_mode(mode0), .o_sel(sel0)
    );

    multi_team_scorer #(.TEAMS(2), .MAX_SCORE(12), .DEB_CYCLES(4), .SCAN_CYCLES(4)) dut12 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_key_A(k12[0]), .I_key_B(k12[1]), .I_key_C(k12[2]), .I_key_D(k12[3]),
        .o_led(led12), .o_dx(dx12), .o_mode(mode12), .o_sel(sel12)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Key vector order {D,C,B,A}; held 20 cycles high then 20 low
    task automatic press(input logic [3:0] k, input bit u12);
        @(negedge clk);
        if (u12) k12 = k; else k0 = k;
        repeat (20) @(negedge clk);
        k0 = 4'b0;
        k12 = 4'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic digit(input string tag, input int d, input bit u12, input logic [6:0] exp);
        int n;
        logic [3:0] want;
        n = 0;
        want = 4'(1 << d);
        @(negedge clk);
        while ((u12 ? dx12 : dx0) != want && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_dx"}, u12 ? dx12 : dx0, want);
        chk(tag, u12 ? led12 : led0, exp);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dx", dx0, 4'b0001);
        chk("rst_led", led0, 7'h3F);
        chk("rst_mode", mode0, 1'b0);
        chk("rst_sel", sel0, 2'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (3) press(4'b0010, 1'b0);
        digit("t0_03_ones", 0, 1'b0, 7'h4F);
        digit("t0_03_tens", 1, 1'b0, 7'h00);
        chk("mode_add", mode0, 1'b0);

        // A press latency: edge 0 is the first posedge after raising the key
        @(negedge clk);
        k0 = 4'b0001;
        repeat (8) @(posedge clk);
        #1 chk("lat_A_before", mode0, 1'b0);
        @(posedge clk);
        #1 chk("lat_A_after", mode0, 1'b1);
        repeat (12) @(negedge clk);
        k0 = 4'b0;
        repeat (20) @(negedge clk);

        press(4'b0010, 1'b0);
        digit("sub_02", 0, 1'b0, 7'h5B);
        press(4'b0010, 1'b0);
        digit("sub_01", 0, 1'b0, 7'h06);
        press(4'b0010, 1'b0);
        digit("sub_00", 0, 1'b0, 7'h3F);
        press(4'b0010, 1'b0);
        digit("sub_hold", 0, 1'b0, 7'h3F);
        digit("sub_tens", 1, 1'b0, 7'h00);

        press(4'b0001, 1'b0);
        chk("mode_back_add", mode0, 1'b0);
        press(4'b0100, 1'b0);
        chk("sel_1", sel0, 2'd1);
        press(4'b0010, 1'b0);
        press(4'b0010, 1'b0);
        digit("t1_02_ones", 2, 1'b0, 7'h5B);
        digit("t1_02_tens", 3, 1'b0, 7'h00);
        digit("t0_kept", 0, 1'b0, 7'h3F);
        press(4'b0100, 1'b0);
        chk("sel_wrap", sel0, 2'd0);

        @(negedge clk);
        k0 = 4'b0010;
        repeat (3) @(negedge clk);
        k0 = 4'b0;
        repeat (20) @(negedge clk);
        digit("glitch", 0, 1'b0, 7'h3F);

        press(4'b0010, 1'b0);
        digit("t0_01", 0, 1'b0, 7'h06);
        press(4'b0100, 1'b0);
        chk("sel_1b", sel0, 2'd1);
        press(4'b1010, 1'b0);
        digit("clr_t0", 0, 1'b0, 7'h3F);
        digit("clr_t1", 2, 1'b0, 7'h3F);
        digit("clr_t1_tens", 3, 1'b0, 7'h00);
        chk("clr_sel", sel0, 2'd1);
        chk("clr_mode", mode0, 1'b0);

        press(4'b0001, 1'b0);
        chk("mode_sub2", mode0, 1'b1);
        begin
            int n;
            n = 0;
            while (dx0 != 4'b0100 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("pre_rst_dx", dx0, 4'b0100);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_dx", dx0, 4'b0001);
        chk("arst_led", led0, 7'h3F);
        chk("arst_mode", mode0, 1'b0);
        chk("arst_sel", sel0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("scan_%0d", i), dx0, (i < 3) ? 4'b0001 : 4'b0010);
        end
        digit("arst_t1", 2, 1'b0, 7'h3F);

        repeat (10) press(4'b0010, 1'b1);
        digit("m12_10_tens", 1, 1'b1, 7'h06);
        digit("m12_10_ones", 0, 1'b1, 7'h3F);
        repeat (5) press(4'b0010, 1'b1);
        digit("m12_sat_ones", 0, 1'b1, 7'h5B);
        digit("m12_sat_tens", 1, 1'b1, 7'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
